// File: rtl/onehot_priority_encoder_seq_if.sv
// Purpose: code handshake bundle between the priority encoder and its consumer.
// Latency: none, wires only.
// Backpressure: code_ready from the consumer stalls the producer's code_valid.
interface onehot_priority_encoder_seq_if;
   logic       code_valid;
   logic       code_ready;
   logic [1:0] code_out;
   logic       multi_hot;

   modport master (
      output code_valid,
      output code_out,
      output multi_hot,
      input  code_ready
   );

   modport slave (
      input  code_valid,
      input  code_out,
      input  multi_hot,
      output code_ready
   );
endinterface

// File: rtl/onehot_priority_encoder_seq.sv
// Purpose: debounced 4-to-2 priority encoder emitting one event per new stable pattern.
// Latency: code_valid rises STABLE_CYCLES-1 edges after the pattern is first sampled.
// Backpressure: one held event; a new event arriving while held and not ready is dropped and counted.
module onehot_priority_encoder_seq #(
   parameter int STABLE_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [3:0]                    d_in,
   onehot_priority_encoder_seq_if.master code_if,
   output logic [CNT_W-1:0]              err_count
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cand_q;
   logic [3:0]       cnt_q;
   logic [3:0]       last_acc_q;
   logic [1:0]       code_q;
   logic             mh_q;
   logic [CNT_W-1:0] err_q;

   logic             accept;
   logic             new_evt;
   logic             load;
   logic             drop;
   logic             err_inc;
   logic [1:0]       enc_code;
   logic             enc_mh;

   // Acceptance happens on the enabled edge where the stability count reaches STABLE.
   always_comb begin
      accept = 1'b0;
      if (en) begin
         if (d_in != cand_q) begin
            accept = (STABLE == 4'd1);
         end else begin
            accept = (cnt_q < STABLE) && ((cnt_q + 4'd1) == STABLE);
         end
      end
   end

   // Highest set bit wins; a pattern is multi-hot if clearing its lowest set bit leaves bits behind.
   always_comb begin
      enc_code = 2'd0;
      if (d_in[3]) begin
         enc_code = 2'd3;
      end else if (d_in[2]) begin
         enc_code = 2'd2;
      end else if (d_in[1]) begin
         enc_code = 2'd1;
      end
      enc_mh = ((d_in & (d_in - 4'd1)) != 4'd0);
   end

   // Zero and repeated patterns only refresh last_acc; they never raise an event.
   assign new_evt = accept && (d_in != 4'd0) && (d_in != last_acc_q);

   // Output FSM: decide whether a new event loads, replaces a handed-off code, or is dropped.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (new_evt) begin
               load    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (code_if.code_ready) begin
               if (new_evt) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (new_evt) begin
               drop = 1'b1;
            end
         end
      endcase
      // A dropped multi-hot event is never loaded, so it counts once.
      err_inc = drop | (load & enc_mh);
   end

   // Input filter: candidate pattern, its stability count and the last accepted pattern.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q     <= 4'd0;
         cnt_q      <= 4'd0;
         last_acc_q <= 4'd0;
      end else if (en) begin
         if (d_in != cand_q) begin
            cand_q <= d_in;
            cnt_q  <= 4'd1;
         end else if (cnt_q < STABLE) begin
            cnt_q <= cnt_q + 4'd1;
         end
         if (accept) begin
            last_acc_q <= d_in;
         end
      end
   end

   // Output registers: FSM state, held code and the saturating error counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         code_q  <= 2'd0;
         mh_q    <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            code_q <= enc_code;
            mh_q   <= enc_mh;
         end
         if (err_inc && (err_q != {CNT_W{1'b1}})) begin
            err_q <= err_q + CNT_W'(1);
         end
      end
   end

   assign code_if.code_valid = (state_q == HOLD);
   assign code_if.code_out   = code_q;
   assign code_if.multi_hot  = mh_q;
   assign err_count          = err_q;

endmodule
